lcd_pixel_fifo: RTL and testbench

- Single-clock pixel FIFO that sits directly upstream of the LCD pixel writer in pipe_6_lcd.
- Accepts 24-bit RGB888 pixels from pipe_5 with a valid/ready handshake.
- Presents first-word-fall-through rgb and bufferEmpty to the writer, which pops one pixel per rendered dclk.
- Tracks frame-start tags, fill level and underruns so the writer stalls cleanly instead of emitting garbage.

---
 rtl/gpu_lcd_pkg.sv | 29 ++
 rtl/lcd_fifo_mem.sv | 34 +++
 rtl/lcd_pixel_fifo.sv | 128 ++++++++++++
 tb/tb_lcd_pixel_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_lcd_pkg.sv
// ============================================================================
// gpu_lcd_pkg : pixel type, LCD panel timing and default FIFO sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package gpu_lcd_pkg;

  localparam int PIXEL_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // 480x272 panel timing, in dclk / line units
  localparam int HOR_PIX = 480;
  localparam int VER_PIX = 272;
  localparam int THBP    = 43;
  localparam int THFP    = 2;
  localparam int TVBP    = 12;
  localparam int TVFP    = 1;

  localparam int FIFO_DEPTH = 64;

endpackage

`default_nettype wire

// File: rtl/lcd_fifo_mem.sv
// ============================================================================
// lcd_fifo_mem : simple dual-port register array, synchronous write and
// asynchronous read.
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_fifo_mem #(
  parameter int WIDTH  = 25,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/lcd_pixel_fifo.sv
// ============================================================================
// lcd_pixel_fifo : first-word-fall-through RGB888 pixel FIFO feeding the LCD
// writer. Optional macro LCD_FIFO_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun counter output.
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_pixel_fifo
  import gpu_lcd_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AFULL_LVL = 56
) (
  input  logic               clk_12mhz,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_rgb,
  input  logic               in_sof,
  input  logic               rd_en,
  input  logic               flush,
  input  logic               clear_status,
  output logic [PIXEL_W-1:0] rgb,
  output logic               out_sof,
  output logic               bufferEmpty,
  output logic [ADDR_W:0]    level,
  output logic               almost_full,
  output logic               underrun
`ifdef LCD_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        underrun_cnt
`endif
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [PTR_W-1:0]   level_next;
  logic               full;
  logic               empty;
  logic               do_wr;
  logic               do_rd;
  logic               rd_on_empty;
  logic [PIXEL_W:0]   head;

  // flush squashes any same-cycle handshake
  assign do_wr       = in_valid && !full  && !flush;
  assign do_rd       = rd_en    && !empty && !flush;
  assign rd_on_empty = rd_en    && empty;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (do_wr) wr_ptr_next = wr_ptr + 1'b1;
      if (do_rd) rd_ptr_next = rd_ptr + 1'b1;
    end
  end

  assign level_next = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      level       <= level_next;
      full        <= (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                     (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
      empty       <= (wr_ptr_next == rd_ptr_next);
      almost_full <= (level_next >= PTR_W'(AFULL_LVL));
      // a fresh underrun beats a same-cycle clear
      if (rd_on_empty) begin
        underrun <= 1'b1;
      end else if (clear_status) begin
        underrun <= 1'b0;
      end
    end
  end

`ifdef LCD_FIFO_UNDERRUN_CNT_EN
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (clear_status) begin
      underrun_cnt <= '0;
    end else if (rd_on_empty && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

  lcd_fifo_mem #(
    .WIDTH  (PIXEL_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk_12mhz),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({in_sof, in_rgb}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (head)
  );

  assign in_ready    = !full;
  assign bufferEmpty = empty;
  assign rgb         = empty ? '0   : head[PIXEL_W-1:0];
  assign out_sof     = empty ? 1'b0 : head[PIXEL_W];

endmodule

`default_nettype wire

// File: tb/tb_lcd_pixel_fifo.sv
// ============================================================================
// tb_lcd_pixel_fifo : vector table, directed corner sequences and random
// traffic against a queue-based reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_pixel_fifo;

  localparam int DEPTH = 64;
  localparam int AFULL = 56;

  logic        clk_12mhz = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        in_sof = 1'b0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic        clear_status = 1'b0;
  logic        in_ready;
  logic [23:0] rgb;
  logic        out_sof;
  logic        bufferEmpty;
  logic [6:0]  level;
  logic        almost_full;
  logic        underrun;
`ifdef LCD_FIFO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  lcd_pixel_fifo dut (
    .clk_12mhz    (clk_12mhz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rgb       (in_rgb),
    .in_sof       (in_sof),
    .rd_en        (rd_en),
    .flush        (flush),
    .clear_status (clear_status),
    .rgb          (rgb),
    .out_sof      (out_sof),
    .bufferEmpty  (bufferEmpty),
    .level        (level),
    .almost_full  (almost_full),
    .underrun     (underrun)
`ifdef LCD_FIFO_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int total = 0;
  int bad = 0;

  // reference model: queue of {sof, rgb}, sticky flag, counter
  logic [24:0] q[$];
  bit          m_under = 1'b0;
  int          m_cnt = 0;

  typedef struct {
    bit          v;
    logic [23:0] d;
    bit          s;
    bit          r;
    bit          f;
    bit          c;
    int          e_level;
    bit          e_empty;
    logic [23:0] e_rgb;
    bit          e_sof;
    bit          e_under;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_under = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_update(input bit v, input logic [23:0] d, input bit s,
                              input bit r, input bit f, input bit c);
    bit was_empty;
    bit was_full;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if (r && was_empty) m_under = 1'b1;
    else if (c)         m_under = 1'b0;
    if (c) m_cnt = 0;
    else if (r && was_empty && m_cnt < 65535) m_cnt++;
    if (f) begin
      q.delete();
    end else begin
      if (r && !was_empty) void'(q.pop_front());
      if (v && !was_full) q.push_back({s, d});
    end
  endtask

  task automatic check_model();
    logic [24:0] h;
    h = '0;
    if (q.size() > 0) h = q[0];
    chk("level", 32'(level), q.size());
    chk("bufferEmpty", 32'(bufferEmpty), 32'(q.size() == 0));
    chk("rgb", 32'(rgb), 32'(h[23:0]));
    chk("out_sof", 32'(out_sof), 32'(h[24]));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    chk("underrun", 32'(underrun), 32'(m_under));
`ifdef LCD_FIFO_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), m_cnt);
`endif
  endtask

  task automatic step(input bit v, input logic [23:0] d, input bit s,
                      input bit r, input bit f, input bit c);
    in_valid = v; in_rgb = d; in_sof = s; rd_en = r; flush = f; clear_status = c;
    @(posedge clk_12mhz);
    #1;
    model_update(v, d, s, r, f, c);
    check_model();
    in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_status = 1'b0; in_sof = 1'b0;
  endtask

  task automatic do_flush();
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst.level", 32'(level), 0);
    chk("rst.empty", 32'(bufferEmpty), 1);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.rgb", 32'(rgb), 0);
    chk("rst.underrun", 32'(underrun), 0);
    chk("rst.almost_full", 32'(almost_full), 0);
    @(negedge clk_12mhz);
    reset = 1'b0;
    model_reset();

    // vector table from an empty FIFO
    tbl[0] = '{1'b1, 24'hFF8000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 24'hFF8000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 24'h00ABCD, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 24'hFF8000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 24'h111111, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 24'h00ABCD, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 24'h111111, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 24'h000000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 24'h000000, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 24'h000000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 24'h000000, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 24'h222222, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 24'h222222, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 24'h333333, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 24'h000000, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].f, tbl[i].c);
      chk("tbl.level", 32'(level), tbl[i].e_level);
      chk("tbl.empty", 32'(bufferEmpty), 32'(tbl[i].e_empty));
      chk("tbl.rgb", 32'(rgb), 32'(tbl[i].e_rgb));
      chk("tbl.sof", 32'(out_sof), 32'(tbl[i].e_sof));
      chk("tbl.underrun", 32'(underrun), 32'(tbl[i].e_under));
    end

    // fill then drain
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 24'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fill.level", 32'(level), i);
      chk("fill.in_ready", 32'(in_ready), 32'(i < DEPTH));
      chk("fill.almost_full", 32'(almost_full), 32'(i >= AFULL));
    end
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain.rgb", 32'(rgb), i);
      step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain.empty", 32'(bufferEmpty), 1);

    // full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.in_ready", 32'(in_ready), 0);
    step(1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full.rw.level", 32'(level), 63);
    chk("full.rw.in_ready", 32'(in_ready), 1);
    do_flush();

    // FWFT latency
    step(1'b1, 24'hFF8000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwft.rgb", 32'(rgb), 32'hFF8000);
    chk("fwft.empty", 32'(bufferEmpty), 0);
    chk("fwft.level", 32'(level), 1);
    do_flush();

    // underrun for three cycles, then clear
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("under.flag", 32'(underrun), 1);
    chk("under.level", 32'(level), 0);
`ifdef LCD_FIFO_UNDERRUN_CNT_EN
    chk("under.cnt", 32'(underrun_cnt), 3);
`endif
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("under.clear", 32'(underrun), 0);

    // flush with a concurrent write, then sof tag
    for (int i = 0; i < 10; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush.pre", 32'(level), 10);
    step(1'b1, 24'h777777, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush.level", 32'(level), 0);
    chk("flush.empty", 32'(bufferEmpty), 1);
    step(1'b1, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sof.tag", 32'(out_sof), 1);
    chk("sof.rgb", 32'(rgb), 32'h123456);
    do_flush();

    // async reset mid-burst, with an underrun pending to be cleared
    step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("areset.pre", 32'(level), 20);
    in_valid = 1'b1; in_rgb = 24'h555555;
    #2 reset = 1'b1;
    #1;
    chk("areset.level", 32'(level), 0);
    chk("areset.empty", 32'(bufferEmpty), 1);
    chk("areset.in_ready", 32'(in_ready), 1);
    chk("areset.rgb", 32'(rgb), 0);
    chk("areset.underrun", 32'(underrun), 0);
    model_reset();
    @(negedge clk_12mhz);
    reset = 1'b0;
    in_valid = 1'b0;
    step(1'b1, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("areset.resume", 32'(rgb), 32'h0A0B0C);

    // random traffic in alternating fill-heavy / drain-heavy phases
    for (int blk = 0; blk < 12; blk++) begin
      int pw;
      int pr;
      pw = (blk % 2 == 0) ? 85 : 35;
      pr = (blk % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 250; i++) begin
        step(($urandom % 100) < pw, 24'($urandom), ($urandom % 8) == 0,
             ($urandom % 100) < pr, ($urandom % 150) == 0, ($urandom % 40) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
